fifo_sync_ctrl: RTL and testbench
=================================

FIFO_SYNC_CTRL -- requirements
Module: fifo_sync_ctrl

Interface
REQ-001 The module SHALL have parameter DW, default 104, meaning data width in bits.
REQ-002 The module SHALL have parameter AW, default 2, meaning address width; memory depth MD = 2^AW.
REQ-003 The module SHALL have parameter PROG_FULL, default MD-1, meaning the stored-word threshold for prog_full.
REQ-004 clk  input  1  single clock; all state changes on its rising edge.
REQ-005 reset  input  1  synchronous, active-high reset.
REQ-006 wr_access  input  1  write request; the word is the value on the external memory's data input.
REQ-007 full  output  1  memory holds MD words; write requests are rejected.
REQ-008 prog_full  output  1  memory holds PROG_FULL or more words.
REQ-009 overflow  output  1  sticky flag: a write was attempted while full.
REQ-010 mem_write  output  1  write enable to the external memory.
REQ-011 mem_wr_addr  output  AW  write address to the external memory.
REQ-012 mem_rd_addr  output  AW  read address to the external memory, which reads combinationally.
REQ-013 mem_rd_data  input  DW  combinational read data from the external memory.
REQ-014 rd_access  output  1  rd_data holds a valid word.
REQ-015 rd_data  output  DW  registered output word.
REQ-016 rd_wait  input  1  consumer back-pressure; the word is consumed in any cycle where rd_access=1 and rd_wait=0.
REQ-017 count  output  AW+1  number of words currently held in memory, excluding the output register.

Function
REQ-018 Pointers: wr_ptr and rd_ptr SHALL each be AW+1 bits wide. The low AW bits form the address; the MSB is a wrap bit.
REQ-019 Address outputs: mem_wr_addr SHALL equal wr_ptr[AW-1:0], and mem_rd_addr SHALL equal rd_ptr[AW-1:0].
REQ-020 Flags: empty (internal) SHALL be true when wr_ptr==rd_ptr. full SHALL be true when the pointers differ only in the MSB. count SHALL equal wr_ptr-rd_ptr modulo 2^(AW+1).
REQ-021 full, prog_full and count SHALL be combinational from the current pointers.
REQ-022 Write acceptance: mem_write SHALL equal wr_access & ~full. When mem_write=1, wr_ptr SHALL increment at the clock edge.
REQ-023 Write while full: a write with full=1 SHALL be dropped and SHALL set overflow. This holds even if a pop occurs in the same cycle.
REQ-024 Pop condition: pop SHALL be ~empty & (~rd_access | ~rd_wait).
REQ-025 Pop action: on pop, rd_data SHALL load mem_rd_data, rd_access SHALL be set, and rd_ptr SHALL increment.
REQ-026 Consume without refill: if the output word is consumed and pop=0 (memory empty), rd_access SHALL clear at the edge.
REQ-027 Hold under back-pressure: while rd_access=1 and rd_wait=1, rd_data and rd_access SHALL hold unchanged.
REQ-028 Latency: a word with wr_access high in cycle N SHALL appear on rd_access/rd_data no earlier than cycle N+2. With an empty FIFO and rd_wait=0, it SHALL appear exactly in cycle N+2.
REQ-029 Throughput: with both sides continuously active and 0<count<MD, one write and one pop SHALL occur every cycle, with count unchanged.
REQ-030 Simultaneous write and pop with empty=1: only the write SHALL take effect, and the word SHALL be popped the following cycle.
REQ-031 Pointer wrap-around past 2^(AW+1)-1 SHALL be seamless with no data loss or reordering.
REQ-032 Capacity: total capacity SHALL be MD+1 words (memory plus output register).
REQ-033 Ordering: words SHALL exit in exactly the order accepted.

Reset
REQ-034 With reset=1 at a clock edge, wr_ptr, rd_ptr, rd_access and overflow SHALL clear to 0; reset takes priority over any write or pop in the same cycle.
REQ-035 rd_data SHALL reset to 0.
REQ-036 After reset: full=0, prog_full=0, count=0, mem_write=0 until a write is requested.
REQ-037 Reset mid-operation SHALL discard all stored and output words. Memory contents need not be cleared.

Verification (AW=2, MD=4, PROG_FULL=3)
REQ-038 Single word: write 0xA5 with rd_wait=0 in cycle 0 -> rd_access=1 and rd_data=0xA5 in cycle 2 only; count returns to 0.
REQ-039 Fill under back-pressure: hold rd_wait=1 and write 6 words -> words 1..5 are accepted (1 in the output register, 4 in memory), full=1, prog_full=1, count=4. Word 6 is dropped and overflow=1. Release rd_wait -> words 1..5 exit in order.
REQ-040 Streaming: 20 back-to-back writes with rd_wait=0 -> 20 reads in order at one per cycle; pointers wrap at least twice; full never asserts.
REQ-041 Back-pressure hold: toggle rd_wait randomly during a 50-word stream -> rd_data is stable whenever rd_wait=1; no loss or duplication.
REQ-042 Full plus pop: at full, assert wr_access together with a consume -> the write is rejected, overflow=1, and count drops to 3.
REQ-043 Reset mid-stream: assert reset with count=3 and rd_access=1 -> the next cycle shows rd_access=0, count=0, overflow=0, full=0.

Source files
------------

// File: rtl/fifo_sync_ctrl_if.sv
// fifo_sync_ctrl_if: write/read handshake and external-memory bus of the FIFO controller
interface fifo_sync_ctrl_if #(
  parameter int DW = 104,
  parameter int AW = 2
);
  logic          wr_access;
  logic          full;
  logic          prog_full;
  logic          overflow;
  logic          mem_write;
  logic [AW-1:0] mem_wr_addr;
  logic [AW-1:0] mem_rd_addr;
  logic [DW-1:0] mem_rd_data;
  logic          rd_access;
  logic [DW-1:0] rd_data;
  logic          rd_wait;
  logic [AW:0]   count;
  modport master (
    input  wr_access, mem_rd_data, rd_wait,
    output full, prog_full, overflow, mem_write, mem_wr_addr, mem_rd_addr, rd_access, rd_data, count
  );
  modport slave (
    output wr_access, mem_rd_data, rd_wait,
    input  full, prog_full, overflow, mem_write, mem_wr_addr, mem_rd_addr, rd_access, rd_data, count
  );
endinterface

// File: rtl/fifo_sync_ctrl.sv
// fifo_sync_ctrl: pointer/flag control for a synchronous FIFO over an external memory, with a registered output word
module fifo_sync_ctrl #(
  parameter int DW = 104,
  parameter int AW = 2,
  parameter int PROG_FULL = (1 << AW) - 1
) (
  input logic              clk,
  input logic              reset,
  fifo_sync_ctrl_if.master bus
);
  logic [AW:0]   r_wr_ptr, r_rd_ptr, w_count;
  logic [DW-1:0] r_rd_data;
  logic          r_rd_access, r_overflow, w_empty, w_full, w_write, w_pop;
  always_comb begin
    w_count = r_wr_ptr - r_rd_ptr;
    w_empty = r_wr_ptr == r_rd_ptr;
    w_full  = (r_wr_ptr ^ r_rd_ptr) == {1'b1, {AW{1'b0}}};
    w_write = bus.wr_access & ~w_full;
    w_pop   = ~w_empty & (~r_rd_access | ~bus.rd_wait);
  end
  assign bus.full        = w_full;
  assign bus.prog_full   = w_count >= (AW+1)'(PROG_FULL);
  assign bus.count       = w_count;
  assign bus.overflow    = r_overflow;
  assign bus.mem_write   = w_write;
  assign bus.mem_wr_addr = r_wr_ptr[AW-1:0];
  assign bus.mem_rd_addr = r_rd_ptr[AW-1:0];
  assign bus.rd_access   = r_rd_access;
  assign bus.rd_data     = r_rd_data;
  always_ff @(posedge clk) begin
    if (reset) begin
      r_wr_ptr    <= '0;
      r_rd_ptr    <= '0;
      r_rd_access <= 1'b0;
      r_overflow  <= 1'b0;
      r_rd_data   <= '0;
    end else begin
      if (w_write) r_wr_ptr <= r_wr_ptr + (AW+1)'(1);
      if (bus.wr_access & w_full) r_overflow <= 1'b1;
      // refill the output register whenever it is free or being consumed
      if (w_pop) begin
        r_rd_ptr    <= r_rd_ptr + (AW+1)'(1);
        r_rd_data   <= bus.mem_rd_data;
        r_rd_access <= 1'b1;
      end else if (~bus.rd_wait) begin
        r_rd_access <= 1'b0;
      end
    end
  end
endmodule

// File: tb/tb_fifo_sync_ctrl.sv
// tb_fifo_sync_ctrl: randomized + directed bench with a queue-based reference model and scoreboard
module tb_fifo_sync_ctrl;
  localparam int DW = 104, AW = 2, MD = 4, PF = 3;
  logic          clk = 1'b0;
  logic          reset;
  logic [DW-1:0] wdata;
  logic [DW-1:0] mem [MD];
  int            total = 0, bad = 0;
  fifo_sync_ctrl_if #(.DW(DW), .AW(AW)) bus();
  fifo_sync_ctrl #(.DW(DW), .AW(AW), .PROG_FULL(PF)) dut (.clk(clk), .reset(reset), .bus(bus));
  always #5 clk = ~clk;
  always @(posedge clk) if (bus.mem_write) mem[bus.mem_wr_addr] <= wdata;
  assign bus.mem_rd_data = mem[bus.mem_rd_addr];
  task automatic chk(input string nm, input logic [DW-1:0] act, input logic [DW-1:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", nm, act, exp);
    end
  endtask
  function automatic logic [DW-1:0] rnd();
    logic [127:0] t = {$urandom(), $urandom(), $urandom(), $urandom()};
    return t[DW-1:0];
  endfunction
  // reference model: words held in memory, output-register occupancy, sticky overflow
  int            m_cnt = 0;
  bit            m_out_v = 0, m_ov = 0;
  logic [DW-1:0] exp_q[$];
  always @(posedge clk) begin
    bit acc, pop;
    if (reset) begin
      m_cnt = 0;
      m_out_v = 0;
      m_ov = 0;
      exp_q.delete();
    end else begin
      acc = bus.wr_access && m_cnt < MD;
      pop = m_cnt > 0 && (!m_out_v || !bus.rd_wait);
      if (bus.wr_access && m_cnt == MD) m_ov = 1;
      if (pop) begin
        m_cnt--;
        m_out_v = 1;
      end else if (!bus.rd_wait) m_out_v = 0;
      if (acc) begin
        m_cnt++;
        exp_q.push_back(wdata);
      end
    end
  end
  // monitor: flags against the model, consumed words against the scoreboard queue
  logic [DW-1:0] hold_data;
  bit            hold = 0;
  int            n_out = 0;
  always @(negedge clk) begin
    chk("count", DW'(bus.count), DW'(m_cnt));
    chk("full", DW'(bus.full), DW'(m_cnt == MD));
    chk("prog_full", DW'(bus.prog_full), DW'(m_cnt >= PF));
    chk("overflow", DW'(bus.overflow), DW'(m_ov));
    chk("rd_access", DW'(bus.rd_access), DW'(m_out_v));
    chk("mem_write", DW'(bus.mem_write), DW'(bus.wr_access && m_cnt < MD));
    if (hold) chk("hold_data", bus.rd_data, hold_data);
    hold = bus.rd_access && bus.rd_wait && !reset;
    hold_data = bus.rd_data;
    if (bus.rd_access && !bus.rd_wait && !reset) begin
      if (exp_q.size() == 0) begin
        total++;
        bad++;
        $display("FAIL order: got %0h want <no word>", bus.rd_data);
      end else chk("order", bus.rd_data, exp_q.pop_front());
      n_out++;
    end
  end
  task automatic step(input bit w, input logic [DW-1:0] d, input bit rw);
    bus.wr_access = w;
    wdata = d;
    bus.rd_wait = rw;
    @(posedge clk);
    #1;
  endtask
  initial begin
    int  base;
    bit  saw_full;
    reset = 1'b1;
    bus.wr_access = 1'b0;
    bus.rd_wait = 1'b0;
    wdata = '0;
    step(0, 0, 0);
    step(0, 0, 0);
    reset = 1'b0;
    chk("rst_count", DW'(bus.count), 0);
    chk("rst_full", DW'(bus.full), 0);
    chk("rst_prog_full", DW'(bus.prog_full), 0);
    chk("rst_mem_write", DW'(bus.mem_write), 0);
    chk("rst_rd_access", DW'(bus.rd_access), 0);
    chk("rst_rd_data", bus.rd_data, 0);
    chk("rst_overflow", DW'(bus.overflow), 0);
    step(1, 'hA5, 0);
    chk("lat_c1_rd_access", DW'(bus.rd_access), 0);
    step(0, 0, 0);
    chk("lat_c2_rd_access", DW'(bus.rd_access), 1);
    chk("lat_c2_rd_data", bus.rd_data, 'hA5);
    step(0, 0, 0);
    chk("lat_c3_rd_access", DW'(bus.rd_access), 0);
    chk("lat_c3_count", DW'(bus.count), 0);
    for (int i = 1; i <= 6; i++) step(1, DW'('h100 + i), 1);
    chk("fill_full", DW'(bus.full), 1);
    chk("fill_prog_full", DW'(bus.prog_full), 1);
    chk("fill_count", DW'(bus.count), 4);
    chk("fill_overflow", DW'(bus.overflow), 1);
    chk("fill_rd_data", bus.rd_data, 'h101);
    step(1, 'h999, 0);
    chk("fullpop_count", DW'(bus.count), 3);
    chk("fullpop_overflow", DW'(bus.overflow), 1);
    chk("fullpop_rd_data", bus.rd_data, 'h102);
    for (int i = 0; i < 8; i++) step(0, 0, 0);
    chk("fill_drained", DW'(exp_q.size()), 0);
    chk("fill_words_out", DW'(n_out), 6);
    base = n_out;
    saw_full = 0;
    for (int i = 0; i < 20; i++) begin
      step(1, DW'('h2000 + i), 0);
      saw_full |= bus.full;
    end
    for (int i = 0; i < 4; i++) step(0, 0, 0);
    chk("stream_words_out", DW'(n_out - base), 20);
    chk("stream_no_full", DW'(saw_full), 0);
    for (int i = 0; i < 150; i++) step(1'($urandom_range(0, 1)), rnd(), 1'($urandom_range(0, 1)));
    for (int i = 0; i < 10; i++) step(0, 0, 0);
    chk("random_drained", DW'(exp_q.size()), 0);
    step(1, 'h3FF, 1);
    for (int i = 0; i < 5; i++) step(1, DW'('h300 + i), 1);
    step(1, 'h777, 1);
    chk("prerst_overflow", DW'(bus.overflow), 1);
    step(0, 0, 0);
    step(0, 0, 0);
    for (int i = 0; i < 4; i++) step(0, 0, 0);
    for (int i = 0; i < 4; i++) step(1, DW'('h400 + i), 1);
    chk("prerst_count", DW'(bus.count), 3);
    chk("prerst_rd_access", DW'(bus.rd_access), 1);
    reset = 1'b1;
    step(0, 0, 1);
    reset = 1'b0;
    chk("midrst_rd_access", DW'(bus.rd_access), 0);
    chk("midrst_count", DW'(bus.count), 0);
    chk("midrst_overflow", DW'(bus.overflow), 0);
    chk("midrst_full", DW'(bus.full), 0);
    step(1, 'hBEEF, 0);
    step(0, 0, 0);
    chk("postrst_rd_data", bus.rd_data, 'hBEEF);
    for (int i = 0; i < 3; i++) step(0, 0, 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
